// File: rtl/input_conditioner_if.sv
// Raw pushbutton/tilt inputs and the conditioned levels handed to the pet FSM.
interface input_conditioner_if;
   logic       btn_sleep_n;
   logic       btn_awake_n;
   logic       btn_feed_n;
   logic       btn_play_n;
   logic       btn_test_n;
   logic       giro_raw;
   logic       sleep_o;
   logic       awake_o;
   logic       play_o;
   logic       feed_o;
   logic       giro_o;
   logic       test_mode;
   logic [3:0] pulse_test;

   modport master (
      output btn_sleep_n, btn_awake_n, btn_feed_n, btn_play_n, btn_test_n, giro_raw,
      input  sleep_o, awake_o, play_o, feed_o, giro_o, test_mode, pulse_test
   );

   modport slave (
      input  btn_sleep_n, btn_awake_n, btn_feed_n, btn_play_n, btn_test_n, giro_raw,
      output sleep_o, awake_o, play_o, feed_o, giro_o, test_mode, pulse_test
   );
endinterface

// File: rtl/input_conditioner.sv
// Synchronise/debounce pushbuttons and tilt sensor, stretch feed, run the test-mode long/short press FSM.
// Define GIRO_DEBOUNCE_EN to debounce the tilt input like the buttons; otherwise it is only synchronised.
module input_conditioner #(
   parameter int unsigned TICK_DIV     = 50000,
   parameter int unsigned DEBOUNCE_MS  = 20,
   parameter int unsigned HOLD_MS      = 3000,
   parameter int unsigned FEED_STRETCH = 100000
) (
   input  logic               clk,
   input  logic               rst,
   input_conditioner_if.slave ic
);

   localparam int unsigned IDX_SLEEP = 0;
   localparam int unsigned IDX_AWAKE = 1;
   localparam int unsigned IDX_FEED  = 2;
   localparam int unsigned IDX_PLAY  = 3;
   localparam int unsigned IDX_TEST  = 4;
   localparam int unsigned IDX_GIRO  = 5;
   localparam int unsigned NUM_RAW   = 6;
`ifdef GIRO_DEBOUNCE_EN
   localparam int unsigned NUM_DEB   = 6;
`else
   localparam int unsigned NUM_DEB   = 5;
`endif
   localparam int unsigned TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned DEB_W     = $clog2(DEBOUNCE_MS + 1);
   localparam int unsigned HOLD_W    = $clog2(HOLD_MS + 1);
   localparam int unsigned STR_W     = $clog2(FEED_STRETCH + 1);
   localparam logic [NUM_DEB-1:0] ACT_LOW = NUM_DEB'(5'b11111);

   typedef enum logic [1:0] {
      T_IDLE  = 2'd0,
      T_PRESS = 2'd1,
      T_LONG  = 2'd2
   } t_state_e;

   logic [NUM_RAW-1:0] raw_in, sync1_q, sync2_q;
   logic [NUM_DEB-1:0] sync_lvl, deb_q, deb_d;
   logic [TICK_W-1:0]  tick_q, tick_d;
   logic               tick;
   logic [STR_W-1:0]   str_q, str_d;
   logic               feed_rise;
   logic               feed_q, sleep_q, awake_q, play_q;
   t_state_e           state_q, state_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic               test_mode_q, test_mode_d;
   logic [3:0]         pulse_q, pulse_d;

   assign raw_in   = {ic.giro_raw, ic.btn_test_n, ic.btn_play_n,
                      ic.btn_feed_n, ic.btn_awake_n, ic.btn_sleep_n};
   assign sync_lvl = sync2_q[NUM_DEB-1:0] ^ ACT_LOW;

   assign tick   = (tick_q == TICK_W'(TICK_DIV - 1));
   assign tick_d = tick ? '0 : tick_q + TICK_W'(1);

   // Per-input debounce: accept a new level after DEBOUNCE_MS consecutive differing ticks
   for (genvar g = 0; g < NUM_DEB; g++) begin : g_deb
      logic [DEB_W-1:0] cnt_q, cnt_d;
      logic             lvl_q, lvl_d;

      always_comb begin
         cnt_d = cnt_q;
         lvl_d = lvl_q;
         if (tick) begin
            if (sync_lvl[g] != lvl_q) begin
               if (cnt_q == DEB_W'(DEBOUNCE_MS - 1)) begin
                  lvl_d = sync_lvl[g];
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + DEB_W'(1);
               end
            end else begin
               cnt_d = '0;
            end
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
         end
      end

      assign deb_q[g] = lvl_q;
      assign deb_d[g] = lvl_d;
   end

   // Feed stretch: load on the cycle the debounced level rises, so feed_o spans exactly FEED_STRETCH cycles
   assign feed_rise = deb_d[IDX_FEED] & ~deb_q[IDX_FEED] & ~test_mode_q;
   assign str_d     = feed_rise       ? STR_W'(FEED_STRETCH) :
                      (str_q != '0)   ? str_q - STR_W'(1)    : '0;

   // Test-button FSM: short press steps pulse_test in test mode, long press toggles test mode
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      test_mode_d = test_mode_q;
      pulse_d     = pulse_q;
      case (state_q)
         T_IDLE: begin
            if (deb_q[IDX_TEST]) begin
               state_d = T_PRESS;
               hold_d  = '0;
            end
         end
         T_PRESS: begin
            if (!deb_q[IDX_TEST]) begin
               if (test_mode_q) begin
                  pulse_d = (pulse_q == 4'd0 || pulse_q >= 4'd9) ? 4'd1 : pulse_q + 4'd1;
               end
               state_d = T_IDLE;
            end else if (tick) begin
               if (hold_q == HOLD_W'(HOLD_MS - 1)) begin
                  test_mode_d = ~test_mode_q;
                  if (!test_mode_q) begin
                     pulse_d = 4'd0;
                  end
                  hold_d  = '0;
                  state_d = T_LONG;
               end else begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
         end
         T_LONG: begin
            if (!deb_q[IDX_TEST]) begin
               state_d = T_IDLE;
            end
         end
         default: state_d = T_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         tick_q      <= '0;
         str_q       <= '0;
         feed_q      <= 1'b0;
         sleep_q     <= 1'b0;
         awake_q     <= 1'b0;
         play_q      <= 1'b0;
         state_q     <= T_IDLE;
         hold_q      <= '0;
         test_mode_q <= 1'b0;
         pulse_q     <= 4'd0;
      end else begin
         sync1_q     <= raw_in;
         sync2_q     <= sync1_q;
         tick_q      <= tick_d;
         str_q       <= str_d;
         feed_q      <= (str_d != '0);
         sleep_q     <= deb_d[IDX_SLEEP] & ~test_mode_d;
         awake_q     <= deb_d[IDX_AWAKE] & ~test_mode_d;
         play_q      <= deb_d[IDX_PLAY]  & ~test_mode_d;
         state_q     <= state_d;
         hold_q      <= hold_d;
         test_mode_q <= test_mode_d;
         pulse_q     <= pulse_d;
      end
   end

   assign ic.sleep_o    = sleep_q;
   assign ic.awake_o    = awake_q;
   assign ic.play_o     = play_q;
   assign ic.feed_o     = feed_q;
   assign ic.test_mode  = test_mode_q;
   assign ic.pulse_test = pulse_q;
`ifdef GIRO_DEBOUNCE_EN
   assign ic.giro_o     = deb_q[IDX_GIRO];
`else
   assign ic.giro_o     = sync2_q[IDX_GIRO];
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with shortened timing (tick = 4 clk, debounce 3, hold 10, stretch 8).
module tb_input_conditioner;

   localparam int unsigned TICK_DIV     = 4;
   localparam int unsigned DEBOUNCE_MS  = 3;
   localparam int unsigned HOLD_MS      = 10;
   localparam int unsigned FEED_STRETCH = 8;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   input_conditioner_if ifc ();

   input_conditioner #(
      .TICK_DIV     (TICK_DIV),
      .DEBOUNCE_MS  (DEBOUNCE_MS),
      .HOLD_MS      (HOLD_MS),
      .FEED_STRETCH (FEED_STRETCH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .ic  (ifc.slave)
   );

   // Edge/level monitors sampled on the falling edge
   int   play_rises = 0, play_falls = 0, feed_rises = 0, feed_high = 0, giro_rises = 0;
   logic play_prev = 1'b0, feed_prev = 1'b0, giro_prev = 1'b0;
   always @(negedge clk) begin
      if (ifc.play_o === 1'b1 && play_prev === 1'b0) play_rises++;
      if (ifc.play_o === 1'b0 && play_prev === 1'b1) play_falls++;
      if (ifc.feed_o === 1'b1 && feed_prev === 1'b0) feed_rises++;
      if (ifc.feed_o === 1'b1) feed_high++;
      if (ifc.giro_o === 1'b1 && giro_prev === 1'b0) giro_rises++;
      play_prev = ifc.play_o;
      feed_prev = ifc.feed_o;
      giro_prev = ifc.giro_o;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ifc.btn_sleep_n = 1'b1;
      ifc.btn_awake_n = 1'b1;
      ifc.btn_feed_n  = 1'b1;
      ifc.btn_play_n  = 1'b1;
      ifc.btn_test_n  = 1'b1;
      ifc.giro_raw    = 1'b0;
      cyc(3);
      checks++;
      if ({ifc.sleep_o, ifc.awake_o, ifc.play_o, ifc.feed_o, ifc.giro_o, ifc.test_mode} !== 6'b0) begin
         errors++;
         $display("FAIL reset_levels got %b exp 000000",
                  {ifc.sleep_o, ifc.awake_o, ifc.play_o, ifc.feed_o, ifc.giro_o, ifc.test_mode});
      end
      checks++;
      if (ifc.pulse_test !== 4'd0) begin
         errors++;
         $display("FAIL reset_pulse got %0d exp 0", ifc.pulse_test);
      end
      rst = 1'b0;
      cyc(30);
   endtask

   task automatic test_play();
      int r0, f0;
      r0 = play_rises;
      f0 = play_falls;
      for (int i = 0; i < 5; i++) begin
         ifc.btn_play_n = (i % 2 == 1);
         cyc(2);
      end
      ifc.btn_play_n = 1'b0;
      cyc(20);
      checks++;
      if (ifc.play_o !== 1'b1) begin
         errors++;
         $display("FAIL play_press got %b exp 1", ifc.play_o);
      end
      cyc(40);
      ifc.btn_play_n = 1'b1;
      cyc(8);
      checks++;
      if (ifc.play_o !== 1'b1) begin
         errors++;
         $display("FAIL play_release_early got %b exp 1", ifc.play_o);
      end
      cyc(12);
      checks++;
      if (ifc.play_o !== 1'b0) begin
         errors++;
         $display("FAIL play_release got %b exp 0", ifc.play_o);
      end
      checks++;
      if (play_rises - r0 !== 1 || play_falls - f0 !== 1) begin
         errors++;
         $display("FAIL play_edges got rises %0d falls %0d exp 1 1", play_rises - r0, play_falls - f0);
      end
      cyc(10);
   endtask

   task automatic test_feed();
      int r0, h0;
      r0 = feed_rises;
      h0 = feed_high;
      ifc.btn_feed_n = 1'b0;
      cyc(200);
      ifc.btn_feed_n = 1'b1;
      cyc(30);
      checks++;
      if (feed_rises - r0 !== 1 || feed_high - h0 !== 8) begin
         errors++;
         $display("FAIL feed_long_hold got pulses %0d cycles %0d exp 1 8", feed_rises - r0, feed_high - h0);
      end
      r0 = feed_rises;
      h0 = feed_high;
      ifc.btn_feed_n = 1'b0;
      cyc(30);
      ifc.btn_feed_n = 1'b1;
      cyc(30);
      checks++;
      if (feed_rises - r0 !== 1 || feed_high - h0 !== 8) begin
         errors++;
         $display("FAIL feed_second got pulses %0d cycles %0d exp 1 8", feed_rises - r0, feed_high - h0);
      end
   endtask

   task automatic test_long_press();
      int r0;
      ifc.btn_test_n = 1'b0;
      cyc(30);
      checks++;
      if (ifc.test_mode !== 1'b0) begin
         errors++;
         $display("FAIL long_too_early got %b exp 0", ifc.test_mode);
      end
      cyc(40);
      checks++;
      if (ifc.test_mode !== 1'b1 || ifc.pulse_test !== 4'd0) begin
         errors++;
         $display("FAIL long_enter got mode %b pulse %0d exp 1 0", ifc.test_mode, ifc.pulse_test);
      end
      ifc.btn_test_n = 1'b1;
      cyc(30);
      ifc.btn_sleep_n = 1'b0;
      cyc(30);
      checks++;
      if (ifc.sleep_o !== 1'b0) begin
         errors++;
         $display("FAIL sleep_masked got %b exp 0", ifc.sleep_o);
      end
      ifc.btn_sleep_n = 1'b1;
      cyc(30);
      r0 = feed_rises;
      ifc.btn_feed_n = 1'b0;
      cyc(30);
      ifc.btn_feed_n = 1'b1;
      cyc(30);
      checks++;
      if (feed_rises - r0 !== 0 || ifc.pulse_test !== 4'd0) begin
         errors++;
         $display("FAIL feed_in_test got pulses %0d pulse_test %0d exp 0 0", feed_rises - r0, ifc.pulse_test);
      end
   endtask

   task automatic short_press();
      ifc.btn_test_n = 1'b0;
      cyc(25);
      ifc.btn_test_n = 1'b1;
      cyc(30);
   endtask

   task automatic test_short_press();
      for (int i = 0; i < 3; i++) short_press();
      checks++;
      if (ifc.pulse_test !== 4'd3) begin
         errors++;
         $display("FAIL short_three got %0d exp 3", ifc.pulse_test);
      end
      for (int i = 0; i < 6; i++) short_press();
      checks++;
      if (ifc.pulse_test !== 4'd9) begin
         errors++;
         $display("FAIL short_nine got %0d exp 9", ifc.pulse_test);
      end
      short_press();
      checks++;
      if (ifc.pulse_test !== 4'd1) begin
         errors++;
         $display("FAIL short_wrap got %0d exp 1", ifc.pulse_test);
      end
      for (int i = 0; i < 2; i++) short_press();
      checks++;
      if (ifc.pulse_test !== 4'd3 || ifc.test_mode !== 1'b1) begin
         errors++;
         $display("FAIL short_twelve got pulse %0d mode %b exp 3 1", ifc.pulse_test, ifc.test_mode);
      end
   endtask

   task automatic test_exit();
      ifc.btn_test_n = 1'b0;
      cyc(70);
      checks++;
      if (ifc.test_mode !== 1'b0 || ifc.pulse_test !== 4'd3) begin
         errors++;
         $display("FAIL exit_long got mode %b pulse %0d exp 0 3", ifc.test_mode, ifc.pulse_test);
      end
      ifc.btn_test_n = 1'b1;
      cyc(30);
      checks++;
      if (ifc.pulse_test !== 4'd3) begin
         errors++;
         $display("FAIL exit_release got %0d exp 3", ifc.pulse_test);
      end
      ifc.btn_sleep_n = 1'b0;
      cyc(30);
      checks++;
      if (ifc.sleep_o !== 1'b1) begin
         errors++;
         $display("FAIL sleep_after_exit got %b exp 1", ifc.sleep_o);
      end
      ifc.btn_sleep_n = 1'b1;
      cyc(30);
   endtask

   task automatic test_reset_mid();
      ifc.btn_test_n = 1'b0;
      cyc(70);
      ifc.btn_test_n = 1'b1;
      cyc(30);
      checks++;
      if (ifc.test_mode !== 1'b1 || ifc.pulse_test !== 4'd0) begin
         errors++;
         $display("FAIL reenter got mode %b pulse %0d exp 1 0", ifc.test_mode, ifc.pulse_test);
      end
      ifc.btn_play_n = 1'b0;
      ifc.btn_test_n = 1'b0;
      cyc(30);
      checks++;
      if (ifc.play_o !== 1'b0) begin
         errors++;
         $display("FAIL play_masked got %b exp 0", ifc.play_o);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({ifc.sleep_o, ifc.awake_o, ifc.play_o, ifc.feed_o, ifc.test_mode} !== 5'b0 ||
          ifc.pulse_test !== 4'd0) begin
         errors++;
         $display("FAIL reset_mid got levels %b pulse %0d exp 00000 0",
                  {ifc.sleep_o, ifc.awake_o, ifc.play_o, ifc.feed_o, ifc.test_mode}, ifc.pulse_test);
      end
      cyc(3);
      rst = 1'b0;
      cyc(5);
      checks++;
      if (ifc.play_o !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_early got %b exp 0", ifc.play_o);
      end
      cyc(20);
      checks++;
      if (ifc.play_o !== 1'b1 || ifc.test_mode !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_press got play %b mode %b exp 1 0", ifc.play_o, ifc.test_mode);
      end
      ifc.btn_play_n = 1'b1;
      ifc.btn_test_n = 1'b1;
      cyc(30);
      checks++;
      if (ifc.test_mode !== 1'b0 || ifc.pulse_test !== 4'd0 || ifc.play_o !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_release got mode %b pulse %0d play %b exp 0 0 0",
                  ifc.test_mode, ifc.pulse_test, ifc.play_o);
      end
   endtask

   task automatic test_giro();
`ifdef GIRO_DEBOUNCE_EN
      int g0;
      g0 = giro_rises;
      ifc.giro_raw = 1'b1;
      cyc(5);
      ifc.giro_raw = 1'b0;
      cyc(30);
      checks++;
      if (giro_rises - g0 !== 0 || ifc.giro_o !== 1'b0) begin
         errors++;
         $display("FAIL giro_glitch got rises %0d level %b exp 0 0", giro_rises - g0, ifc.giro_o);
      end
      ifc.giro_raw = 1'b1;
      cyc(25);
      checks++;
      if (ifc.giro_o !== 1'b1) begin
         errors++;
         $display("FAIL giro_steady got %b exp 1", ifc.giro_o);
      end
      ifc.giro_raw = 1'b0;
      cyc(25);
      checks++;
      if (ifc.giro_o !== 1'b0) begin
         errors++;
         $display("FAIL giro_release got %b exp 0", ifc.giro_o);
      end
`else
      ifc.giro_raw = 1'b1;
      cyc(1);
      checks++;
      if (ifc.giro_o !== 1'b0) begin
         errors++;
         $display("FAIL giro_lat1 got %b exp 0", ifc.giro_o);
      end
      cyc(1);
      checks++;
      if (ifc.giro_o !== 1'b1) begin
         errors++;
         $display("FAIL giro_lat2 got %b exp 1", ifc.giro_o);
      end
      ifc.giro_raw = 1'b0;
      cyc(1);
      checks++;
      if (ifc.giro_o !== 1'b1) begin
         errors++;
         $display("FAIL giro_fall1 got %b exp 1", ifc.giro_o);
      end
      cyc(1);
      checks++;
      if (ifc.giro_o !== 1'b0) begin
         errors++;
         $display("FAIL giro_fall2 got %b exp 0", ifc.giro_o);
      end
`endif
      cyc(10);
   endtask

   initial begin
      test_reset();
      test_play();
      test_feed();
      test_long_press();
      test_short_press();
      test_exit();
      test_reset_mid();
      test_giro();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
